// File: rtl/ad7476_spi_master.sv
// ad7476_spi_master: reads 16-bit frames from an AD7476-class ADC and presents the 12-bit sample over valid/ready
module ad7476_spi_master #(
    parameter int CLK_DIV      = 4,
    parameter int QUIET_CYCLES = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic        trigger_i,
    input  logic        clear_i,
    output logic        spi_ss_o,
    output logic        spi_sck_o,
    input  logic        spi_miso_i,
    output logic [11:0] sample_o,
    output logic        sample_valid_o,
    input  logic        sample_ready_i,
    output logic        lead_err_o,
    output logic        overrun_o,
    output logic        busy_o
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

    state_t        state, next;
    logic [DW-1:0] div_cnt;
    logic [4:0]    bit_cnt;
    logic [QW-1:0] quiet_cnt;
    logic [15:0]   shreg;
    logic          div_last, fall, done, load, ss_d, sck_d;

    assign div_last = div_cnt == DIV_LAST;
    assign busy_o   = state != IDLE;

    // state register
    always_ff @(posedge clk_i) state <= !rst_n_i ? IDLE : next;

    // next-state: a frame ends after the high phase of the 16th sck period
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = (enable_i | trigger_i) ? SETUP : IDLE;
            SETUP:   next = div_last ? SHIFT : SETUP;
            SHIFT:   next = (div_last && spi_sck_o && bit_cnt == 5'd15) ? QUIET : SHIFT;
            QUIET:   next = quiet_cnt == QUIET_LAST ? IDLE : QUIET;
            default: next = IDLE;
        endcase
    end

    // output decode: pin levels for the next cycle, miso capture on every sck fall, completion handshake
    always_comb begin
        done  = state == SHIFT && next == QUIET;
        fall  = div_last && spi_sck_o && (state == SETUP || (state == SHIFT && !done));
        load  = done && (!sample_valid_o || sample_ready_i);
        ss_d  = !(next == SETUP || next == SHIFT);
        sck_d = next == SHIFT ? spi_sck_o ^ div_last : 1'b1;
    end

    // counters, shift register and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            div_cnt        <= '0;
            bit_cnt        <= '0;
            quiet_cnt      <= '0;
            shreg          <= '0;
            spi_ss_o       <= 1'b1;
            spi_sck_o      <= 1'b1;
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            lead_err_o     <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            div_cnt        <= ((state == SETUP || state == SHIFT) && !div_last) ? div_cnt + 1'b1 : '0;
            bit_cnt        <= state == SETUP ? '0 : (state == SHIFT && div_last && spi_sck_o) ? bit_cnt + 1'b1 : bit_cnt;
            quiet_cnt      <= state == QUIET ? quiet_cnt + 1'b1 : '0;
            shreg          <= fall ? {shreg[14:0], spi_miso_i} : shreg;
            spi_ss_o       <= ss_d;
            spi_sck_o      <= sck_d;
            sample_o       <= load ? shreg[11:0] : sample_o;
            sample_valid_o <= load | (sample_valid_o & ~sample_ready_i);
            lead_err_o     <= done && shreg[15:12] != 4'd0;
            overrun_o      <= (done & ~load) | (overrun_o & ~clear_i);
        end
    end
endmodule

// File: tb/tb_ad7476_spi_master.sv
// tb_ad7476_spi_master: randomized scoreboard bench with an ADC serializer model and a frame-level reference
module tb_ad7476_spi_master;
    localparam int D   = 4;
    localparam int Q   = 8;
    localparam int LOW = 33 * D;

    logic clk = 0, rst_n = 0, enable = 0, trigger = 0, clear = 0, ready = 0, miso = 0;
    logic ss, sck, valid, lead, ovr, busy;
    logic [11:0] sample;

    ad7476_spi_master #(.CLK_DIV(D), .QUIET_CYCLES(Q)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .trigger_i(trigger), .clear_i(clear),
        .spi_ss_o(ss), .spi_sck_o(sck), .spi_miso_i(miso),
        .sample_o(sample), .sample_valid_o(valid), .sample_ready_i(ready),
        .lead_err_o(lead), .overrun_o(ovr), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    bit chk_on = 0;
    logic [11:0] adc_cnt = 0;
    bit force_ones = 0;

    // reference model state: m_c is the cycle index since the accepted start (1 = first ss-low cycle)
    bit          m_act = 0, m_valid = 0, m_ovr = 0, m_lead = 0, m_done = 0, m_load = 0;
    int          m_c = 0;
    logic [15:0] m_word = 0;
    logic [11:0] m_sample = 0;
    logic [11:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_sck(input bit act, input int c);
        return !(act && c >= 1 + D && c <= LOW && ((c - 1 - D) % (2 * D)) < D);
    endfunction

    // frame-level reference: completion after 33D low cycles, then Q quiet cycles before idle
    always @(posedge clk) begin
        if (!rst_n) begin
            m_act = 0; m_c = 0; m_valid = 0; m_ovr = 0; m_lead = 0; m_sample = 0;
            exp_q.delete();
        end else begin
            m_done = m_act && m_c == LOW;
            m_load = m_done && (!m_valid || ready);
            m_lead = m_done && m_word[15:12] != 4'd0;
            if (m_load) begin
                m_sample = m_word[11:0];
                exp_q.push_back(m_word[11:0]);
            end
            m_valid = m_load ? 1'b1 : (m_valid && ready) ? 1'b0 : m_valid;
            m_ovr = (m_done && !m_load) ? 1'b1 : clear ? 1'b0 : m_ovr;
            if (!m_act && (enable || trigger)) begin
                m_act = 1; m_c = 1; m_word = force_ones ? 16'hFFFF : {4'h0, adc_cnt};
            end else if (m_act) begin
                if (m_c == LOW + Q) m_act = 0;
                else m_c++;
            end
        end
    end

    // ADC serializer: MSB appears when ss falls, next bit after each sck fall
    logic        ss_prev = 1, sck_prev = 1;
    logic [15:0] ser_word = 0;
    int          ser_idx = 0;
    always @(negedge clk) begin
        if (ss_prev === 1'b1 && ss === 1'b0) begin
            ser_word = force_ones ? 16'hFFFF : {4'h0, adc_cnt};
            ser_idx = 15;
        end else if (ss === 1'b0 && sck_prev === 1'b1 && sck === 1'b0 && ser_idx > 0) ser_idx--;
        miso = ser_word[ser_idx];
        ss_prev = ss;
        sck_prev = sck;
    end

    // monitor: per-cycle pin/flag check plus scoreboard pop on every handshake
    always @(negedge clk) if (chk_on) begin
        chk("ss", ss, !(m_act && m_c <= LOW));
        chk("sck", sck, exp_sck(m_act, m_c));
        chk("busy", busy, m_act);
        chk("valid", valid, m_valid);
        chk("sample", sample, m_sample);
        chk("lead_err", lead, m_lead);
        chk("overrun", ovr, m_ovr);
        if (valid === 1'b1 && ready) begin
            chk("hs_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("hs_sample", sample, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic trig();
        trigger = 1;
        step();
        trigger = 0;
    endtask

    task automatic wait_c(input int c);
        int n = 0;
        while (!(m_act && m_c == c) && n < 2000) begin step(); n++; end
        chk("wait_frame_pos", n < 2000, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_act && n < 2000) begin step(); n++; end
        chk("wait_idle", n < 2000, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] w1, w3;
        enable = 1;
        rst_n = 0;
        step();
        chk_on = 1;
        step();
        step();
        chk("reset_busy", busy, 0);
        chk("reset_ss", ss, 1);
        rst_n = 1;
        step();
        chk("start_after_reset", busy, 1);
        enable = 0;
        ready = 1;
        wait_idle();

        adc_cnt = 12'hABC;
        trig();
        wait_c(LOW + 1);
        chk("abc_sample", sample, 12'hABC);
        chk("abc_valid", valid, 1);
        chk("abc_lead", lead, 0);
        wait_idle();

        adc_cnt = 12'h0FF;
        enable = 1;
        for (int i = 0; i < 3; i++) begin
            wait_c(LOW + 1);
            chk("cont_sample", sample, 12'h0FF + i);
            adc_cnt++;
            step();
        end
        enable = 0;
        chk("cont_overrun", ovr, 0);
        wait_idle();

        ready = 0;
        adc_cnt = 12'($urandom);
        w1 = adc_cnt;
        trig();
        wait_idle();
        adc_cnt = 12'($urandom);
        trig();
        wait_idle();
        chk("bp_sample", sample, w1);
        chk("bp_overrun", ovr, 1);
        ready = 1;
        step();
        ready = 0;
        chk("bp_consumed", valid, 0);
        clear = 1;
        step();
        clear = 0;
        chk("bp_cleared", ovr, 0);

        adc_cnt = 12'($urandom);
        trig();
        wait_idle();
        adc_cnt = 12'($urandom);
        w3 = adc_cnt;
        trig();
        wait_c(LOW);
        ready = 1;
        step();
        ready = 0;
        chk("simul_sample", sample, w3);
        chk("simul_valid", valid, 1);
        chk("simul_overrun", ovr, 0);
        ready = 1;
        wait_idle();

        force_ones = 1;
        trig();
        wait_c(LOW + 1);
        chk("lead_sample", sample, 12'hFFF);
        chk("lead_pulse", lead, 1);
        step();
        chk("lead_single", lead, 0);
        force_ones = 0;
        wait_idle();

        trig();
        wait_c(1 + 13 * D);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("midrst_ss", ss, 1);
        chk("midrst_sck", sck, 1);
        chk("midrst_valid", valid, 0);
        adc_cnt = 12'($urandom);
        w1 = adc_cnt;
        trig();
        wait_c(LOW + 1);
        chk("midrst_sample", sample, w1);
        wait_idle();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            trigger = $urandom_range(0, 19) == 0;
            ready = $urandom_range(0, 2) != 0;
            clear = $urandom_range(0, 29) == 0;
            rst_n = $urandom_range(0, 499) != 0;
            if (!m_act) begin
                adc_cnt = 12'($urandom);
                force_ones = $urandom_range(0, 15) == 0;
            end
            step();
        end
        rst_n = 1;
        enable = 0;
        trigger = 0;
        clear = 0;
        ready = 1;
        wait_idle();
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
